prog_truth_table: RTL and testbench

- Parametrised, run-time-programmable successor to the fixed 3-input truth-table gate modules.
- Evaluates an N_IN-input Boolean function held in an internal table; the table is loaded serially over a valid/ready configuration port.
- Drives a registered output through a programmable hold filter, which models the settling delay of the gate.
- Sits wherever a fixed single-function gate module would sit, so one block can realise any of the 2^(2^N_IN) functions.

---
 rtl/truth_table_pkg.sv | 16 +
 rtl/hold_filter.sv | 39 +++
 rtl/prog_truth_table.sv | 86 ++++++++
 tb/tb_prog_truth_table.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the programmable truth-table gate.
package truth_table_pkg;

  localparam int unsigned MAX_N_IN = 6;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } state_e;

  function automatic int unsigned depth_of(input int unsigned n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/hold_filter.sv
// Persistence filter: a new raw value must hold for HOLD+1 edges before it reaches out.
module hold_filter
  import truth_table_pkg::*;
#(
  parameter int unsigned HOLD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic out
);

  localparam int unsigned     HW     = (HOLD == 0) ? 1 : $clog2(HOLD + 1);
  localparam logic [HW-1:0]   HOLD_C = HW'(HOLD);

  logic          r_out;
  logic [HW-1:0] r_hcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= 1'b0;
      r_hcnt <= '0;
    end else if (!en) begin
      r_out  <= 1'b0;
      r_hcnt <= '0;
    end else if (raw == r_out) begin
      r_hcnt <= '0;
    end else if (r_hcnt == HOLD_C) begin
      r_out  <= raw;
      r_hcnt <= '0;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign out = r_out;

endmodule

// File: rtl/prog_truth_table.sv
// Run-time programmable N_IN-input Boolean gate; table loaded serially, output hold-filtered.
module prog_truth_table
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN = 3,
  parameter int unsigned HOLD = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            table_valid,
  output logic            out
);

  localparam int unsigned D = depth_of(N_IN);

  state_e          r_state;
  state_e          w_next;
  logic [D-1:0]    r_table;
  logic [N_IN-1:0] r_cnt;
  logic            r_done;
  logic            w_beat;
  logic            w_last;
  logic            w_run;
  logic            w_raw;
  logic            w_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_run     = (r_state == RUN);
    cfg_ready = (r_state == LOAD) && !cfg_start;
    w_beat    = cfg_valid && cfg_ready;
    w_last    = (r_cnt == '1);
    case (r_state)
      EMPTY:   if (cfg_start) w_next = LOAD;
      LOAD:    if (w_beat && w_last) w_next = RUN;
      RUN:     if (cfg_start) w_next = LOAD;
      default: w_next = EMPTY;
    endcase
  end

  // D-1-x equals ~x because D-1 is all ones at N_IN bits wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_table <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_beat && w_last;
      if (cfg_start) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_table[~r_cnt] <= cfg_bit;
        r_cnt           <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign w_raw = r_table[~in];

  hold_filter #(
    .HOLD(HOLD)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_run),
    .raw   (w_raw),
    .out   (w_filt)
  );

  // The filter register clears one edge after leaving RUN, so gate it for the first LOAD cycle.
  assign out         = w_filt & w_run;
  assign table_valid = w_run;
  assign cfg_done    = r_done;

endmodule

// File: tb/tb_prog_truth_table.sv
// Directed self-checking bench for prog_truth_table across four parameter sets.
module tb_prog_truth_table;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start, valid, cbit;
  logic [3:0] ready, done, tv, outv;
  logic [2:0] in_a, in_b;
  logic [0:0] in_c;
  logic [3:0] in_d;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned acc;

  always #5 clk = ~clk;

  prog_truth_table #(.N_IN(3), .HOLD(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .cfg_start(start[0]), .cfg_valid(valid[0]),
    .cfg_bit(cbit[0]), .cfg_ready(ready[0]), .cfg_done(done[0]), .table_valid(tv[0]), .out(outv[0]));
  prog_truth_table #(.N_IN(3), .HOLD(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .cfg_start(start[1]), .cfg_valid(valid[1]),
    .cfg_bit(cbit[1]), .cfg_ready(ready[1]), .cfg_done(done[1]), .table_valid(tv[1]), .out(outv[1]));
  prog_truth_table #(.N_IN(1), .HOLD(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in(in_c), .cfg_start(start[2]), .cfg_valid(valid[2]),
    .cfg_bit(cbit[2]), .cfg_ready(ready[2]), .cfg_done(done[2]), .table_valid(tv[2]), .out(outv[2]));
  prog_truth_table #(.N_IN(4), .HOLD(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in(in_d), .cfg_start(start[3]), .cfg_valid(valid[3]),
    .cfg_bit(cbit[3]), .cfg_ready(ready[3]), .cfg_done(done[3]), .table_valid(tv[3]), .out(outv[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int unsigned idx, input int unsigned v);
    case (idx)
      0:       in_a = 3'(v);
      1:       in_b = 3'(v);
      2:       in_c = 1'(v);
      default: in_d = 4'(v);
    endcase
  endtask

  task automatic load_code(input int unsigned idx, input logic [15:0] code,
                           input int unsigned depth, input bit do_start);
    if (do_start) begin
      start[idx] = 1'b1;
      tick();
      start[idx] = 1'b0;
    end
    check_eq("load_tv_low", tv[idx], 0);
    check_eq("load_out_low", outv[idx], 0);
    for (int unsigned k = 0; k < depth; k++) begin
      valid[idx] = 1'b1;
      cbit[idx]  = code[depth-1-k];
      #1;
      check_eq("load_ready", ready[idx], 1);
      tick();
      check_eq("load_done", done[idx], (k == depth - 1) ? 1 : 0);
    end
    valid[idx] = 1'b0;
    check_eq("load_tv_high", tv[idx], 1);
    tick();
    check_eq("load_done_end", done[idx], 0);
  endtask

  task automatic sweep(input int unsigned idx, input logic [15:0] mask,
                       input int unsigned depth, input string tag);
    for (int unsigned v = 0; v < depth; v++) begin
      set_in(idx, v);
      tick();
      check_eq(tag, outv[idx], mask[v]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = '0; valid = '0; cbit = '0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    tick();
    check_eq("rst_ready", ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_tv", tv, 0);
    check_eq("rst_out", outv, 0);
    rst_n = 1'b1;
    tick();
    check_eq("empty_tv", tv, 0);

    // T1: 0x3E, HOLD=0 -> out=1 for in 2..6
    load_code(0, 16'h003E, 8, 1'b1);
    sweep(0, 16'h007C, 8, "t1_out");
    set_in(0, 2);
    #1;
    check_eq("t1_late", outv[0], 0);
    tick();
    check_eq("t1_next", outv[0], 1);

    // T2: HOLD=2 latency and glitch rejection
    load_code(1, 16'h003E, 8, 1'b1);
    tick();
    check_eq("t2_idle", outv[1], 0);
    set_in(1, 2);
    tick(); check_eq("t2_e1", outv[1], 0);
    tick(); check_eq("t2_e2", outv[1], 0);
    tick(); check_eq("t2_e3", outv[1], 1);
    set_in(1, 0);
    tick(); check_eq("t2_f1", outv[1], 1);
    tick(); check_eq("t2_f2", outv[1], 1);
    tick(); check_eq("t2_f3", outv[1], 0);
    set_in(1, 2);
    tick(); tick();
    set_in(1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_glitch", outv[1], 0);
    end

    // T3: cfg_valid toggling, code 0xA5
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check_eq("t3_tv_drop", tv[0], 0);
    check_eq("t3_out_forced", outv[0], 0);
    acc = 0;
    for (int c = 0; c < 40 && acc < 8; c++) begin
      if (c % 2 == 0) begin
        valid[0] = 1'b1;
        cbit[0]  = 1'(8'hA5 >> (7 - acc));
      end else begin
        valid[0] = 1'b0;
      end
      tick();
      if (c % 2 == 0) acc++;
      check_eq("t3_done", done[0], (c % 2 == 0 && acc == 8) ? 1 : 0);
    end
    valid[0] = 1'b0;
    check_eq("t3_tv", tv[0], 1);
    sweep(0, 16'h00A5, 8, "t3_out");

    // T4: restart after 5 beats, then 0x80
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid[0] = 1'b1;
      cbit[0]  = 1'b1;
      tick();
      check_eq("t4_part_done", done[0], 0);
    end
    start[0] = 1'b1;
    #1;
    check_eq("t4_ready_start", ready[0], 0);
    tick();
    start[0] = 1'b0;
    valid[0] = 1'b0;
    load_code(0, 16'h0080, 8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      valid[0] = 1'b1;
      cbit[0]  = 1'b1;
      #1;
      check_eq("t4_run_ready", ready[0], 0);
      tick();
      check_eq("t4_run_done", done[0], 0);
      check_eq("t4_run_tv", tv[0], 1);
    end
    valid[0] = 1'b0;
    sweep(0, 16'h0001, 8, "t4_out");

    // T5: asynchronous reset mid-load and in RUN
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid[0] = 1'b1;
      cbit[0]  = 1'b1;
      tick();
    end
    check_eq("t5_ready_pre", ready[0], 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_ready_rst", ready[0], 0);
    check_eq("t5_tv_rst", tv[0], 0);
    check_eq("t5_out_rst", outv[0], 0);
    valid[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    valid[0] = 1'b1;
    #1;
    check_eq("t5_empty_ready", ready[0], 0);
    tick();
    check_eq("t5_empty_tv", tv[0], 0);
    valid[0] = 1'b0;
    set_in(0, 0);
    load_code(0, 16'h003E, 8, 1'b1);
    set_in(0, 2);
    tick();
    check_eq("t5_run_out", outv[0], 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_out_rst2", outv[0], 0);
    check_eq("t5_tv_rst2", tv[0], 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T6: N_IN=1 identity, N_IN=4 code 0x8000
    load_code(2, 16'h0001, 2, 1'b1);
    sweep(2, 16'h0002, 2, "t6_n1_out");
    load_code(3, 16'h8000, 16, 1'b1);
    sweep(3, 16'h0001, 16, "t6_n4_out");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
